dsp_mac_sequencer: RTL and testbench
====================================

Name: dsp_mac_sequencer

Overview:
Sequences one DSP48E1 slice as an 8-bit × 8-bit unsigned dot-product engine with bias. It accepts a job (length + 32-bit bias), streams operand pairs into the slice at up to one pair per cycle, and tracks the 2-cycle slice pipeline. It accumulates returned products into a 32-bit result and returns it on a valid/ready port. It sits between the TPU tile controller and a DSP48E1 instance (AREG=BREG=CREG=PREG=1).

Parameters:
LEN_W, 8, width of job_len; maximum job length is 2^LEN_W-1 pairs
ACC_W, 32, accumulator/result width; fixed at 32 for this revision

Ports:
clk  in  1  single clock; also drives DSP48E1 CLK
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_len  in  LEN_W  number of operand pairs, 0 allowed
job_bias  in  32  initial accumulator value
op_valid  in  1  operand pair valid
op_ready  out  1  high only in ISSUE
op_a  in  8  unsigned operand A
op_b  in  8  unsigned operand B
res_valid  out  1  result valid, held until accepted
res_ready  in  1  result consumer ready
res_data  out  32  dot product + bias, mod 2^32
res_ovf  out  1  sticky carry-out of any 32-bit accumulation in this job
dsp_a  out  30  {22'b0, op_a}
dsp_b  out  18  {10'b0, op_b}
dsp_c  out  48  {16'b0, job_bias} on the first issue of a job, else 0
dsp_cea, dsp_ceb, dsp_cec  out  1  each equals the issue strobe (op_valid & op_ready)
dsp_cep  out  1  stage-1 valid: issue strobe delayed one cycle
dsp_rst  out  1  registered; drives RSTA/RSTB/RSTC/RSTM/RSTP
dsp_opmode  out  7  constant 7'b0110101 (C + A*B)
dsp_alumode  out  4  constant 4'b0000
dsp_p  in  48  slice P output

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, accumulator=0, res_valid=0, res_data=0, res_ovf=0, issue count=0, valid pipe=00, dsp_rst=1, all CE outputs 0.
- The clock and reset are fixed as stated: one clock; reset is asynchronous and active-low.
- IDLE:
  - job_ready=1; dsp_rst=1 (registered, so it also goes high in the cycle after leaving DONE).
  - On job_valid: latch job_len and job_bias; set accumulator=0 and res_ovf=0.
  - If len≠0, go to ISSUE. If len=0, go directly to DONE with res_data=bias; the slice is not touched.
- ISSUE:
  - dsp_rst=0 and op_ready=1.
  - Each op handshake is an issue: drive dsp_a/dsp_b, assert cea/ceb/cec, increment the count. dsp_c carries the bias only when count==0.
  - Cycles with op_valid=0 are bubbles: no CE asserted, and no accumulate results from them.
  - After the handshake with count==len-1, go to DRAIN; op_ready drops in the next cycle.
- Pipeline: 2-bit valid shift register v[1:0].
  - v[0] <= issue strobe, and dsp_cep = v[0].
  - v[1] <= v[0]; while v[1]=1, the accumulator takes acc + dsp_p[31:0].
  - A pair issued in cycle t is accumulated at the end of cycle t+2.
  - Carry-out of that add, or dsp_p[47:32]≠0, sets res_ovf.
- DRAIN: wait until v==00 and no add is pending, then go to DONE. Minimum 2 cycles after the last issue.
- DONE:
  - res_valid=1 and res_data=accumulator; both are stable while res_ready=0.
  - On res_ready, go to IDLE with res_valid=0 next cycle.
  - A new job can be accepted one cycle after the result handshake.
- job_valid while not IDLE is ignored (job_ready=0). op_valid outside ISSUE is ignored (op_ready=0).
- Reset mid-job: abandons the job with no result emitted, returns to IDLE values, and holds the slice in reset via dsp_rst.
- Arithmetic:
  - Operands are zero-extended, so products are ≤ 65025.
  - The accumulator wraps mod 2^32; res_ovf records the wrap.

Decomposition:
- Package tpu_mac_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE};
  - constants MAC_OPMODE=7'b0110101, MAC_ALUMODE=4'b0000, DSP_LAT=2, DSP_A_W=30, DSP_B_W=18, DSP_P_W=48.
- One sub-module, dsp_issue_tracker, holds the v[1:0] shift register. It produces dsp_cep, acc_en and pipe_empty.

Test Plan:
- len=3, bias=10, pairs (2,3),(4,5),(255,255) back-to-back → res_data=65061, res_ovf=0; res_valid rises 3 cycles after the last issue (2 cycles in DRAIN).
- len=0, bias=7 → res_valid with res_data=7 one cycle after the job handshake; dsp_cea/ceb/cec/cep never asserted.
- len=4 of (1,1) with op_valid low on alternate cycles → res_data=bias+4; dsp_cea asserted exactly 4 times.
- bias=0xFFFFFFF0, len=1, pair (5,5) → res_data=0x00000009, res_ovf=1; the next job with bias=0 and pair (1,1) → res_data=1, res_ovf=0.
- Hold res_ready=0 for 5 cycles in DONE → res_valid and res_data stable and job_ready=0; a job_valid pulse during this window is not accepted.
- Drop rst_n mid-ISSUE after 2 of 5 pairs → next cycle dsp_rst=1, op_ready=0, res_valid=0; a fresh len=1 job with (3,3), bias=0 → res_data=9.

Source files
------------

// File: rtl/tpu_mac_pkg.sv
// Shared types and constants for the DSP48E1 MAC sequencer.
// The slice is configured as P = C + A*B with AREG=BREG=CREG=PREG=1.
package tpu_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  localparam logic [6:0] MAC_OPMODE  = 7'b0110101;
  localparam logic [3:0] MAC_ALUMODE = 4'b0000;
  localparam int         DSP_LAT     = 2;
  localparam int         DSP_A_W     = 30;
  localparam int         DSP_B_W     = 18;
  localparam int         DSP_C_W     = 48;
  localparam int         DSP_P_W     = 48;

endpackage

// File: rtl/dsp_issue_tracker.sv
// Tracks issued operand pairs through the slice pipeline (input regs, then PREG).
// The last stage marks the cycle in which dsp_p holds a product to accumulate.
module dsp_issue_tracker
  import tpu_mac_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic dsp_cep,
  output logic acc_en,
  output logic pipe_empty
);

  logic [DSP_LAT-1:0] v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[DSP_LAT-2:0], issue};
    end
  end

  assign dsp_cep = v_q[0];
  assign acc_en  = v_q[DSP_LAT-1];
  // True when every pending product retires no later than the coming edge.
  assign pipe_empty = ~issue & ~(|v_q[DSP_LAT-2:0]);

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48E1 as an unsigned 8x8 dot-product engine with a 32-bit bias,
// accumulating slice outputs and returning the result on a valid/ready port.
//
// state | meaning
// IDLE  | slice held in reset, waiting for a job
// ISSUE | accepting operand pairs into the slice
// DRAIN | waiting for in-flight products to be accumulated
// DONE  | result presented until accepted
module dsp_mac_sequencer
  import tpu_mac_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [LEN_W-1:0]     job_len,
  input  logic [ACC_W-1:0]     job_bias,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [7:0]           op_a,
  input  logic [7:0]           op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_data,
  output logic                 res_ovf,
  output logic [DSP_A_W-1:0]   dsp_a,
  output logic [DSP_B_W-1:0]   dsp_b,
  output logic [DSP_C_W-1:0]   dsp_c,
  output logic                 dsp_cea,
  output logic                 dsp_ceb,
  output logic                 dsp_cec,
  output logic                 dsp_cep,
  output logic                 dsp_rst,
  output logic [6:0]           dsp_opmode,
  output logic [3:0]           dsp_alumode,
  input  logic [DSP_P_W-1:0]   dsp_p
);

  mac_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [ACC_W-1:0] bias_q, acc_q, res_data_q, acc_nxt;
  logic [ACC_W:0]   add_sum;
  logic             ovf_q, ovf_nxt, dsp_rst_q;
  logic             job_acc, issue, last_issue, acc_en, pipe_empty;

  assign job_ready  = (state_q == IDLE);
  assign op_ready   = (state_q == ISSUE);
  assign res_valid  = (state_q == DONE);
  assign job_acc    = job_valid & job_ready;
  assign issue      = op_valid & op_ready;
  assign last_issue = issue & (cnt_q == len_q - LEN_W'(1));

  dsp_issue_tracker u_tracker (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .dsp_cep    (dsp_cep),
    .acc_en     (acc_en),
    .pipe_empty (pipe_empty)
  );

  // Bias rides in through C on the first issue, so the first P already includes it.
  always_comb begin
    add_sum = {1'b0, acc_q} + {1'b0, dsp_p[ACC_W-1:0]};
    acc_nxt = acc_q;
    ovf_nxt = ovf_q;
    if (acc_en) begin
      acc_nxt = add_sum[ACC_W-1:0];
      ovf_nxt = ovf_q | add_sum[ACC_W] | (|dsp_p[DSP_P_W-1:ACC_W]);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (job_valid) state_d = (job_len == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      bias_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      res_data_q <= '0;
      dsp_rst_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      // Registered from next state so the first ISSUE cycle already sees rst low.
      dsp_rst_q <= (state_d == IDLE);
      if (job_acc) begin
        len_q  <= job_len;
        bias_q <= job_bias;
        cnt_q  <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
        if (job_len == '0) res_data_q <= job_bias;
      end else begin
        acc_q <= acc_nxt;
        ovf_q <= ovf_nxt;
        if (issue) cnt_q <= cnt_q + LEN_W'(1);
        if ((state_q == DRAIN) && pipe_empty) res_data_q <= acc_nxt;
      end
    end
  end

  assign res_data    = res_data_q;
  assign res_ovf     = ovf_q;
  assign dsp_a       = {{(DSP_A_W-8){1'b0}}, op_a};
  assign dsp_b       = {{(DSP_B_W-8){1'b0}}, op_b};
  assign dsp_c       = (op_ready && (cnt_q == '0)) ? {{(DSP_C_W-ACC_W){1'b0}}, bias_q} : '0;
  assign dsp_cea     = issue;
  assign dsp_ceb     = issue;
  assign dsp_cec     = issue;
  assign dsp_rst     = dsp_rst_q;
  assign dsp_opmode  = MAC_OPMODE;
  assign dsp_alumode = MAC_ALUMODE;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48E1 (C + A*B, registered A/B/C/P)
// feeds dsp_p; expected results come from plain dot-product arithmetic.
module tb_dsp_mac_sequencer;

  localparam int LEN_W = 8;
  localparam int ACC_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len = '0;
  logic [ACC_W-1:0]  job_bias = '0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [7:0]        op_a = '0;
  logic [7:0]        op_b = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic [29:0]       dsp_a;
  logic [17:0]       dsp_b;
  logic [47:0]       dsp_c;
  logic              dsp_cea, dsp_ceb, dsp_cec, dsp_cep, dsp_rst;
  logic [6:0]        dsp_opmode;
  logic [3:0]        dsp_alumode;
  logic [47:0]       dsp_p;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_bias(job_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cec(dsp_cec), .dsp_cep(dsp_cep),
    .dsp_rst(dsp_rst), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode), .dsp_p(dsp_p)
  );

  always #5 clk = ~clk;

  // Slice model: synchronous resets, MREG bypassed.
  logic [47:0] ra = '0, rb = '0, rc = '0, rp = '0;
  always @(posedge clk) begin
    if (dsp_rst) begin
      ra <= '0; rb <= '0; rc <= '0; rp <= '0;
    end else begin
      if (dsp_cea) ra <= {18'b0, dsp_a};
      if (dsp_ceb) rb <= {30'b0, dsp_b};
      if (dsp_cec) rc <= dsp_c;
      if (dsp_cep) rp <= rc + ra * rb;
    end
  end
  assign dsp_p = rp;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] data; logic ovf; } exp_t;
  exp_t exp_q[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cea_cnt = 0, cep_cnt = 0;
  int last_issue_cyc = 0, rise_cyc = 0, job_hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops the scoreboard on each result handshake.
  initial begin
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dsp_cea) begin cea_cnt++; last_issue_cyc = cyc; end
        if (dsp_cep) cep_cnt++;
        if (job_valid && job_ready) job_hs_cyc = cyc;
        if (res_valid && !prev_rv) rise_cyc = cyc;
        check("ce_match", {dsp_ceb, dsp_cec}, {dsp_cea, dsp_cea});
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: got data %0h, required no result", res_data);
          end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_ovf", res_ovf, e.ovf);
          end
        end
      end
      prev_rv = res_valid;
    end
  end

  // bubbles: 0 none, 1 one idle cycle between pairs, 2 random idles.
  task automatic run_job(input int len, input logic [31:0] bias, input int bubbles,
                         input int abort_after, input int stall, input bit pulse);
    longint unsigned tot;
    exp_t e;
    int n;
    tot = longint'(bias);
    for (int i = 0; i < len; i++) tot += longint'(qa[i]) * longint'(qb[i]);
    e.data = tot[31:0];
    e.ovf  = (tot > 64'h0000_0000_FFFF_FFFF);

    @(posedge clk); #1;
    res_ready = (stall == 0);
    job_valid = 1'b1;
    job_len   = LEN_W'(len);
    job_bias  = bias;
    n = 0;
    @(negedge clk);
    while (!job_ready && n < 100) begin @(negedge clk); n++; end
    if (!job_ready) begin timeout("job_handshake"); job_valid = 1'b0; return; end
    @(posedge clk); #1;
    job_valid = 1'b0;
    job_len   = LEN_W'($urandom);
    exp_q.push_back(e);

    for (int i = 0; i < len; i++) begin
      if (i == abort_after) begin
        rst_n = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("abort_dsp_rst", dsp_rst, 1'b1);
        check("abort_op_ready", op_ready, 1'b0);
        check("abort_res_valid", res_valid, 1'b0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if ((bubbles == 1 && i > 0) || (bubbles == 2 && $urandom_range(0, 2) == 0)) begin
        op_valid = 1'b0;
        op_a = 8'($urandom);
        @(posedge clk); #1;
      end
      op_valid = 1'b1;
      op_a = qa[i];
      op_b = qb[i];
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 50) begin @(negedge clk); n++; end
      if (!op_ready) begin timeout("op_handshake"); op_valid = 1'b0; return; end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);

    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    if (!res_valid) begin timeout("res_valid"); return; end
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", res_valid, 1'b1);
      check("stall_data", res_data, e.data);
      check("stall_job_ready", job_ready, 1'b0);
      @(posedge clk); #1;
      job_valid = pulse && (k == 1);
      @(negedge clk);
    end
    job_valid = 1'b0;
    if (stall > 0) begin
      @(posedge clk); #1;
      res_ready = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (res_valid && n < 20) begin @(negedge clk); n++; end
    if (res_valid) timeout("res_accept");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_a, base_p, ln;
    logic [31:0] bias;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_op_ready", op_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_ovf", res_ovf, 1'b0);
    check("rst_dsp_rst", dsp_rst, 1'b1);
    check("rst_ce", {dsp_cea, dsp_ceb, dsp_cec, dsp_cep}, 4'b0000);
    check("opmode", dsp_opmode, 7'b0110101);
    check("alumode", dsp_alumode, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    qa = '{8'd2, 8'd4, 8'd255};
    qb = '{8'd3, 8'd5, 8'd255};
    run_job(3, 32'd10, 0, -1, 0, 1'b0);
    check("drain_latency", rise_cyc - last_issue_cyc, 3);

    base_a = cea_cnt; base_p = cep_cnt;
    run_job(0, 32'd7, 0, -1, 0, 1'b0);
    check("len0_latency", rise_cyc - job_hs_cyc, 1);
    check("len0_cea", cea_cnt - base_a, 0);
    check("len0_cep", cep_cnt - base_p, 0);

    qa = '{8'd1, 8'd1, 8'd1, 8'd1};
    qb = '{8'd1, 8'd1, 8'd1, 8'd1};
    base_a = cea_cnt;
    run_job(4, 32'd1000, 1, -1, 0, 1'b0);
    check("bubble_cea", cea_cnt - base_a, 4);

    qa = '{8'd5};
    qb = '{8'd5};
    run_job(1, 32'hFFFF_FFF0, 0, -1, 0, 1'b0);
    qa = '{8'd1};
    qb = '{8'd1};
    run_job(1, 32'd0, 0, -1, 0, 1'b0);

    qa = '{8'd9, 8'd200};
    qb = '{8'd7, 8'd100};
    run_job(2, 32'd55, 0, -1, 5, 1'b1);

    qa = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55};
    qb = '{8'd66, 8'd77, 8'd88, 8'd99, 8'd111};
    run_job(5, 32'd123, 0, 2, 0, 1'b0);
    qa = '{8'd3};
    qb = '{8'd3};
    run_job(1, 32'd0, 0, -1, 0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      ln = $urandom_range(0, 16);
      qa.delete();
      qb.delete();
      for (int i = 0; i < ln; i++) begin
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
      end
      bias = ($urandom_range(0, 3) == 0) ? (32'hFFFF_0000 | 32'($urandom_range(0, 65535))) : 32'($urandom);
      run_job(ln, bias, 2, -1, $urandom_range(0, 3), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("end_res_valid", res_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
